// File: rtl/brick_align_game.sv
`default_nettype none
// ============================================================================
// Module   : brick_align_game
// Purpose  : Game engine for the three-brick alignment game. Three bricks
//            bounce across rows of WIDTH positions, one row at a time. A stop
//            press freezes the active brick. After the third freeze the three
//            positions are compared, producing a one-cycle aligne pulse or a
//            held perdu level. Every won round shortens the brick step period.
// Ports    : clk    - system clock
//            reset  - synchronous, active-low reset
//            tick   - one-cycle time-base enable
//            stop   - one-cycle debounced player press
//            leds   - 3 rows of WIDTH one-hot brick positions (row k at k*WIDTH)
//            aligne - registered one-cycle pulse on a successful round
//            perdu  - registered level, high while the round is lost
//            level  - rounds won since start, saturating at 15
// Revision : 1.0 - initial release
// ============================================================================
module brick_align_game #(
    parameter int WIDTH     = 8,
    parameter int START_DIV = 8,
    parameter int MIN_DIV   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 stop,
    output logic [3*WIDTH-1:0]   leds,
    output logic                 aligne,
    output logic                 perdu,
    output logic [3:0]           level
);

    localparam int c_POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [c_POS_W-1:0] c_POS_MAX    = c_POS_W'(WIDTH - 1);
    localparam logic [c_POS_W-1:0] c_POS_MAX_M1 = c_POS_W'(WIDTH - 2);
    localparam logic [c_POS_W-1:0] c_POS_ONE    = c_POS_W'(1);
    localparam logic [7:0]         c_START_DIV  = 8'(START_DIV);
    localparam logic [7:0]         c_MIN_DIV    = 8'(MIN_DIV);

    // The low two bits of the move states double as the active row index.
    localparam logic [2:0] c_S_MOVE0 = 3'd0;
    localparam logic [2:0] c_S_MOVE1 = 3'd1;
    localparam logic [2:0] c_S_MOVE2 = 3'd2;
    localparam logic [2:0] c_S_CHECK = 3'd3;
    localparam logic [2:0] c_S_LOST  = 3'd4;

    logic [2:0]         r_state,   w_state_nxt;
    logic [c_POS_W-1:0] r_pos     [3];
    logic [c_POS_W-1:0] w_pos_nxt [3];
    logic               r_dir,     w_dir_nxt;
    logic [7:0]         r_div,     w_div_nxt;
    logic [7:0]         r_div_cnt, w_div_cnt_nxt;
    logic               r_aligne,  w_aligne_nxt;
    logic               r_perdu,   w_perdu_nxt;
    logic [3:0]         r_level,   w_level_nxt;

    logic [1:0]         w_idx;
    logic [c_POS_W-1:0] w_act_pos;
    logic [c_POS_W-1:0] w_step_pos;
    logic               w_step_dir;
    logic [2:0]         w_row_en;

    assign w_idx = r_state[1:0];

    // Position of the brick currently moving (only meaningful in MOVEk).
    always_comb begin
        case (w_idx)
            2'd1:    w_act_pos = r_pos[1];
            2'd2:    w_act_pos = r_pos[2];
            default: w_act_pos = r_pos[0];
        endcase
    end

    // Bounce: the brick reverses on reaching either end of the row.
    always_comb begin
        w_step_pos = w_act_pos;
        w_step_dir = r_dir;
        if (r_dir) begin
            if (w_act_pos == c_POS_MAX) begin
                w_step_pos = c_POS_MAX_M1;
                w_step_dir = 1'b0;
            end else begin
                w_step_pos = w_act_pos + c_POS_ONE;
            end
        end else begin
            if (w_act_pos == '0) begin
                w_step_pos = c_POS_ONE;
                w_step_dir = 1'b1;
            end else begin
                w_step_pos = w_act_pos - c_POS_ONE;
            end
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_pos;
        w_dir_nxt     = r_dir;
        w_div_nxt     = r_div;
        w_div_cnt_nxt = r_div_cnt;
        w_aligne_nxt  = 1'b0;
        w_perdu_nxt   = r_perdu;
        w_level_nxt   = r_level;

        case (r_state)
            c_S_MOVE0, c_S_MOVE1, c_S_MOVE2: begin
                if (stop) begin
                    // Stop takes priority over a coincident step: the active
                    // brick keeps its pre-step position.
                    w_div_cnt_nxt = 8'd0;
                    w_dir_nxt     = 1'b1;
                    case (r_state)
                        c_S_MOVE0: begin
                            w_pos_nxt[1] = '0;
                            w_state_nxt  = c_S_MOVE1;
                        end
                        c_S_MOVE1: begin
                            w_pos_nxt[2] = '0;
                            w_state_nxt  = c_S_MOVE2;
                        end
                        default: w_state_nxt = c_S_CHECK;
                    endcase
                end else if (tick) begin
                    if (r_div_cnt == r_div - 8'd1) begin
                        w_div_cnt_nxt = 8'd0;
                        w_dir_nxt     = w_step_dir;
                        for (int i = 0; i < 3; i++) begin
                            if (w_idx == 2'(i)) w_pos_nxt[i] = w_step_pos;
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + 8'd1;
                    end
                end
            end

            c_S_CHECK: begin
                if ((r_pos[0] == r_pos[1]) && (r_pos[1] == r_pos[2])) begin
                    w_aligne_nxt  = 1'b1;
                    w_level_nxt   = (r_level == 4'd15) ? r_level : r_level + 4'd1;
                    w_div_nxt     = (r_div > c_MIN_DIV) ? r_div - 8'd1 : c_MIN_DIV;
                    w_pos_nxt     = '{default: '0};
                    w_dir_nxt     = 1'b1;
                    w_div_cnt_nxt = 8'd0;
                    w_state_nxt   = c_S_MOVE0;
                end else begin
                    w_perdu_nxt = 1'b1;
                    w_state_nxt = c_S_LOST;
                end
            end

            c_S_LOST: begin
                if (stop) begin
                    w_perdu_nxt   = 1'b0;
                    w_level_nxt   = 4'd0;
                    w_div_nxt     = c_START_DIV;
                    w_pos_nxt     = '{default: '0};
                    w_dir_nxt     = 1'b1;
                    w_div_cnt_nxt = 8'd0;
                    w_state_nxt   = c_S_MOVE0;
                end
            end

            default: w_state_nxt = c_S_MOVE0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_S_MOVE0;
            r_pos     <= '{default: '0};
            r_dir     <= 1'b1;
            r_div     <= c_START_DIV;
            r_div_cnt <= 8'd0;
            r_aligne  <= 1'b0;
            r_perdu   <= 1'b0;
            r_level   <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_dir     <= w_dir_nxt;
            r_div     <= w_div_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_aligne  <= w_aligne_nxt;
            r_perdu   <= w_perdu_nxt;
            r_level   <= w_level_nxt;
        end
    end

    // Row k is shown once its brick has started moving; all rows stay lit
    // through CHECK and LOST.
    assign w_row_en[0] = 1'b1;
    assign w_row_en[1] = (r_state != c_S_MOVE0);
    assign w_row_en[2] = (r_state != c_S_MOVE0) && (r_state != c_S_MOVE1);

    generate
        for (genvar k = 0; k < 3; k++) begin : g_row
            assign leds[k*WIDTH +: WIDTH] =
                w_row_en[k] ? ({{(WIDTH-1){1'b0}}, 1'b1} << r_pos[k]) : '0;
        end
    endgenerate

    assign aligne = r_aligne;
    assign perdu  = r_perdu;
    assign level  = r_level;

endmodule
`default_nettype wire

// File: tb/tb_brick_align_game.sv
`default_nettype none
// ============================================================================
// Module   : tb_brick_align_game
// Purpose  : Self-checking bench for brick_align_game. A reference model
//            tracks each brick as a phase around its bounce cycle and the
//            game as a stage number; the DUT outputs are compared against it
//            every cycle, plus a few hand-computed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brick_align_game;

    localparam int W  = 8;
    localparam int SD = 8;
    localparam int MD = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           tick = 1'b0;
    logic           stop = 1'b0;
    logic [3*W-1:0] leds;
    logic           aligne;
    logic           perdu;
    logic [3:0]     level;

    brick_align_game #(.WIDTH(W), .START_DIV(SD), .MIN_DIV(MD)) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .stop   (stop),
        .leds   (leds),
        .aligne (aligne),
        .perdu  (perdu),
        .level  (level)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int aligne_seen = 0;
    bit chk_en      = 1'b0;

    // Model: stage 0..2 = row moving, 3 = comparing, 4 = lost.
    // The moving brick's position is a triangle function of its phase.
    int m_stage;
    int m_pos [3];
    int m_ph;
    int m_cnt;
    int m_div;
    int m_level;
    bit m_aligne;
    bit m_perdu;

    function automatic int tri_pos(int p);
        return (p < W) ? p : (2*W - 2 - p);
    endfunction

    task automatic model_restart();
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
        m_ph    = 0;
        m_cnt   = 0;
        m_stage = 0;
    endtask

    task automatic model_step();
        m_aligne = 1'b0;
        if (!reset) begin
            model_restart();
            m_div   = SD;
            m_level = 0;
            m_perdu = 1'b0;
        end else if (m_stage <= 2) begin
            if (stop) begin
                m_cnt = 0;
                m_ph  = 0;
                if (m_stage < 2) m_pos[m_stage+1] = 0;
                m_stage++;
            end else if (tick) begin
                m_cnt++;
                if (m_cnt == m_div) begin
                    m_cnt = 0;
                    m_ph  = (m_ph + 1) % (2*W - 2);
                    m_pos[m_stage] = tri_pos(m_ph);
                end
            end
        end else if (m_stage == 3) begin
            if (m_pos[0] == m_pos[1] && m_pos[1] == m_pos[2]) begin
                m_aligne = 1'b1;
                m_level  = (m_level < 15) ? m_level + 1 : 15;
                m_div    = (m_div - 1 > MD) ? m_div - 1 : MD;
                model_restart();
            end else begin
                m_perdu = 1'b1;
                m_stage = 4;
            end
        end else begin
            if (stop) begin
                m_perdu = 1'b0;
                m_level = 0;
                m_div   = SD;
                model_restart();
            end
        end
    endtask

    function automatic logic [3*W-1:0] exp_leds();
        logic [3*W-1:0] e;
        logic [W-1:0]   one;
        e   = '0;
        one = 1;
        for (int k = 0; k < 3; k++) begin
            if (m_stage >= k) e[k*W +: W] = one << m_pos[k];
        end
        return e;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (leds !== exp_leds() || aligne !== m_aligne ||
                perdu !== m_perdu || level !== 4'(m_level)) begin
                miscompares++;
                $display("FAIL cycle t=%0t: leds=%h aligne=%b perdu=%b level=%0d, required leds=%h aligne=%b perdu=%b level=%0d",
                         $time, leds, aligne, perdu, level, exp_leds(), m_aligne, m_perdu, m_level);
            end
            if (aligne === 1'b1) aligne_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic cyc(input bit t, input bit s);
        tick = t;
        stop = s;
        @(posedge clk);
        model_step();
        #1;
        tick = 1'b0;
        stop = 1'b0;
    endtask

    task automatic play_row(input int target, input bit rnd_tick);
        for (int n = 0; n < 2000; n++) begin
            if (m_stage > 2) break;
            if (m_pos[m_stage] == target) begin
                cyc(rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
                return;
            end
            cyc(rnd_tick ? 1'($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
        end
        check("play_row_timeout", 32'(m_stage), 32'(99));
    endtask

    task automatic tick_until_pos(input int row, input int target, input bit on_boundary);
        for (int n = 0; n < 2000; n++) begin
            if (m_pos[row] == target && (!on_boundary || m_cnt == m_div - 1)) return;
            cyc(1'b1, 1'b0);
        end
        check("tick_until_timeout", 32'(m_pos[row]), 32'(target));
    endtask

    initial begin
        int base;
        int a, b, c;

        reset = 1'b0;
        repeat (3) cyc(1'b1, 1'b1);
        reset  = 1'b1;
        chk_en = 1'b1;
        check("reset_leds", 32'(leds), 32'h000001);
        check("reset_level", 32'(level), 32'd0);
        check("reset_perdu", 32'(perdu), 32'd0);

        // Bounce at div=8: 3 steps reach pos 3; 20 steps end at pos 6.
        repeat (24) cyc(1'b1, 1'b0);
        check("bounce_3steps", 32'(leds), 32'h000008);
        repeat (136) cyc(1'b1, 1'b0);
        check("bounce_20steps", 32'(leds), 32'h000040);

        // Aligned round at position 3.
        play_row(3, 1'b0);
        play_row(3, 1'b0);
        play_row(3, 1'b0);
        check("check_leds", 32'(leds), 32'h080808);
        cyc(1'b0, 1'b0);
        check("win_aligne_hi", 32'(aligne), 32'd1);
        check("win_level", 32'(level), 32'd1);
        cyc(1'b0, 1'b0);
        check("win_aligne_lo", 32'(aligne), 32'd0);
        check("win_leds", 32'(leds), 32'h000001);

        // Miss: 3, 3, 4.
        play_row(3, 1'b0);
        play_row(3, 1'b0);
        play_row(4, 1'b0);
        cyc(1'b0, 1'b0);
        check("miss_perdu_hi", 32'(perdu), 32'd1);
        repeat (100) cyc(1'b1, 1'b0);
        check("lost_perdu_held", 32'(perdu), 32'd1);
        check("lost_leds", 32'(leds), 32'h100808);
        cyc(1'b0, 1'b1);
        check("restart_perdu", 32'(perdu), 32'd0);
        check("restart_level", 32'(level), 32'd0);

        // Stop coincident with a step at pos0=2 going up: freezes at 2.
        tick_until_pos(0, 2, 1'b1);
        cyc(1'b1, 1'b1);
        check("stop_wins_row0", 32'(leds[W-1:0]), 32'h04);

        // Reset in MOVE1 with pos1=5.
        tick_until_pos(1, 5, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        check("midreset_leds", 32'(leds), 32'h000001);
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        check("midreset_level", 32'(level), 32'd0);
        check("midreset_perdu", 32'(perdu), 32'd0);

        // Saturation: 20 aligned rounds at random positions.
        base = aligne_seen;
        for (int r = 0; r < 20; r++) begin
            a = $urandom_range(0, W-1);
            play_row(a, 1'b0);
            play_row(a, 1'b0);
            play_row(a, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check("sat_pulses", 32'(aligne_seen - base), 32'd20);
        check("sat_level", 32'(level), 32'd15);
        cyc(1'b1, 1'b0);
        check("sat_div1_step", 32'(leds), 32'h000002);

        // Randomized rounds: random ticks, stops in CHECK, losses, resets.
        for (int r = 0; r < 40; r++) begin
            a = $urandom_range(0, W-1);
            b = ($urandom_range(0, 1) != 0) ? a : $urandom_range(0, W-1);
            c = ($urandom_range(0, 1) != 0) ? a : $urandom_range(0, W-1);
            play_row(a, 1'b1);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b0;
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                reset = 1'b1;
                continue;
            end
            play_row(b, 1'b1);
            play_row(c, 1'b1);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc(1'($urandom_range(0, 1)), 1'b0);
            if (m_stage == 4) begin
                repeat ($urandom_range(1, 5)) cyc(1'($urandom_range(0, 1)), 1'b0);
                cyc(1'($urandom_range(0, 1)), 1'b1);
            end
        end
        repeat (3) cyc(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
